// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger/measure sequencer for six ultrasonic sonars
// fired in pairs (1+2, 3+4, 5+6). Echo widths are converted to cm and packed
// into one 16-bit word per pair. A word changes only in the single S_Store clock,
// so a reader sampling the words at any time never sees half of an update.
module sonar_scheduler #(
   parameter int TRIG_CYCLES  = 500,
   parameter int TICK_CYCLES  = 2900,
   parameter int WAIT_CYCLES  = 50000,
   parameter int GUARD_CYCLES = 1000000
) (
   input  logic        theClock,
   input  logic        theReset,
   input  logic        enable,
   input  logic [5:0]  echo,
   output logic [5:0]  trig,
   output logic [15:0] sonar12,
   output logic [15:0] sonar34,
   output logic [15:0] sonar56,
   output logic        busy,
   output logic [1:0]  pair_idx
);

   typedef enum logic [2:0] {
      S_Idle     = 3'd0,
      S_Trig     = 3'd1,
      S_WaitEcho = 3'd2,
      S_Measure  = 3'd3,
      S_Store    = 3'd4,
      S_Guard    = 3'd5
   } state_t;

   // Trigger lines belonging to a pair.
   function automatic logic [5:0] pair_mask(input logic [1:0] p);
      logic [5:0] m;
      case (p)
         2'd0:    m = 6'b000011;
         2'd1:    m = 6'b001100;
         2'd2:    m = 6'b110000;
         default: m = 6'b000000;
      endcase
      return m;
   endfunction

   state_t            state_r, state_next_s, seq_next_s;
   logic [31:0]       cnt_r;
   logic [5:0]        echo_meta_r, echo_sync_r;
   logic [1:0]        echo_pair_s;          // bit0 = channel A (odd sonar), bit1 = channel B
   logic [1:0]        pair_next_s, seq_pair_s;
   logic              abort_s, wait_expired_s;
   logic [1:0]        risen_r, done_r;
   logic [1:0][15:0]  presc_r, presc_base_s;
   logic [1:0][7:0]   dist_r;

   // Double-flop synchroniser for the asynchronous echo lines.
   always_ff @(posedge theClock or posedge theReset) begin
      if (theReset) begin
         echo_meta_r <= 6'b000000;
         echo_sync_r <= 6'b000000;
      end else begin
         echo_meta_r <= echo;
         echo_sync_r <= echo_meta_r;
      end
   end

   // Select the synchronised echoes of the active pair and the prescaler start values.
   always_comb begin
      echo_pair_s = 2'b00;
      case (pair_idx)
         2'd0:    echo_pair_s = echo_sync_r[1:0];
         2'd1:    echo_pair_s = echo_sync_r[3:2];
         2'd2:    echo_pair_s = echo_sync_r[5:4];
         default: echo_pair_s = 2'b00;
      endcase
      for (int ch = 0; ch < 2; ch++) begin
         // The first high clock of a channel restarts its prescaler.
         presc_base_s[ch] = risen_r[ch] ? presc_r[ch] : 16'd0;
      end
   end

   // Next-state logic; a dropped enable aborts every state except S_Store.
   always_comb begin
      seq_next_s     = state_r;
      seq_pair_s     = pair_idx;
      wait_expired_s = (cnt_r == 32'(WAIT_CYCLES - 1));
      case (state_r)
         S_Idle: begin
            if (enable) seq_next_s = S_Trig;
            else        seq_next_s = S_Idle;
         end
         S_Trig: begin
            if (cnt_r == 32'(TRIG_CYCLES - 1)) seq_next_s = S_WaitEcho;
            else                               seq_next_s = S_Trig;
         end
         S_WaitEcho: begin
            if (echo_pair_s != 2'b00) seq_next_s = S_Measure;
            else if (wait_expired_s)  seq_next_s = S_Store;
            else                      seq_next_s = S_WaitEcho;
         end
         S_Measure: begin
            if (done_r == 2'b11) seq_next_s = S_Store;
            else                 seq_next_s = S_Measure;
         end
         S_Store: begin
            if (enable) seq_next_s = S_Guard;
            else        seq_next_s = S_Idle;
         end
         S_Guard: begin
            if (cnt_r == 32'(GUARD_CYCLES - 1)) begin
               seq_next_s = S_Trig;
               seq_pair_s = (pair_idx == 2'd2) ? 2'd0 : pair_idx + 2'd1;
            end else begin
               seq_next_s = S_Guard;
            end
         end
         default: seq_next_s = S_Idle;
      endcase
      abort_s      = !enable && (state_r != S_Store);
      state_next_s = abort_s ? S_Idle : seq_next_s;
      pair_next_s  = abort_s ? pair_idx : seq_pair_s;
   end

   // State, shared phase counter, pair index and registered trig/busy outputs.
   always_ff @(posedge theClock or posedge theReset) begin
      if (theReset) begin
         state_r  <= S_Idle;
         cnt_r    <= 32'd0;
         pair_idx <= 2'd0;
         trig     <= 6'b000000;
         busy     <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         // The counter restarts on every state change so each phase is timed from its entry.
         cnt_r    <= ((state_next_s != state_r) || (state_next_s == S_Idle)) ? 32'd0 : cnt_r + 32'd1;
         pair_idx <= pair_next_s;
         trig     <= (state_next_s == S_Trig) ? pair_mask(pair_next_s) : 6'b000000;
         busy     <= (state_next_s != S_Idle);
      end
   end

   // Two independent echo-width channels; active from S_WaitEcho through S_Measure.
   always_ff @(posedge theClock or posedge theReset) begin
      if (theReset) begin
         risen_r <= 2'b00;
         done_r  <= 2'b00;
         presc_r <= '0;
         dist_r  <= '0;
      end else if (state_r == S_Trig) begin
         risen_r <= 2'b00;
         done_r  <= 2'b00;
         presc_r <= '0;
         dist_r  <= '0;
      end else if ((state_r == S_WaitEcho) && (state_next_s == S_Store)) begin
         // Neither echo answered in time.
         dist_r <= {8'hFF, 8'hFF};
      end else if ((state_r == S_WaitEcho) || (state_r == S_Measure)) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (!done_r[ch]) begin
               if (echo_pair_s[ch]) begin
                  risen_r[ch] <= 1'b1;
                  if (presc_base_s[ch] == 16'(TICK_CYCLES - 1)) begin
                     presc_r[ch] <= 16'd0;
                     dist_r[ch]  <= dist_r[ch] + 8'd1;
                     // Reaching 255 ends the channel; the value saturates there.
                     if (dist_r[ch] == 8'hFE) done_r[ch] <= 1'b1;
                  end else begin
                     presc_r[ch] <= presc_base_s[ch] + 16'd1;
                  end
               end else if (risen_r[ch]) begin
                  done_r[ch] <= 1'b1;
               end else if ((state_r == S_Measure) && wait_expired_s) begin
                  done_r[ch] <= 1'b1;
                  dist_r[ch] <= 8'hFF;
               end
            end
         end
      end
   end

   // Result words: written only in S_Store, whole word at once.
   always_ff @(posedge theClock or posedge theReset) begin
      if (theReset) begin
         sonar12 <= 16'h0000;
         sonar34 <= 16'h0000;
         sonar56 <= 16'h0000;
      end else if (state_r == S_Store) begin
         case (pair_idx)
            2'd0:    sonar12 <= {dist_r[0], dist_r[1]};
            2'd1:    sonar34 <= {dist_r[0], dist_r[1]};
            2'd2:    sonar56 <= {dist_r[0], dist_r[1]};
            default: sonar12 <= sonar12;
         endcase
      end
   end

endmodule
